// File: rtl/debounce_scan.sv
// Shared-counter button debouncer: one down-the-line window counter is lent round-robin
// to whichever button's synchronized level disagrees with its debounced level.
//
// state  | meaning
// IDLE   | no window open; grant counter to next requesting button
// COUNT  | owner's level differs from btn_o; count tp_i pulses until window full
// COMMIT | one cycle; btn_o[owner] updated, press/release pulse visible
module debounce_scan #(
  parameter int N_BTN           = 4,
  parameter int PULSE_PER_NS    = 5120,
  parameter int DEBOUNCE_PER_NS = 20_971_520
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     tp_i,
  input  logic [N_BTN-1:0]         btn_i,
  output logic [N_BTN-1:0]         btn_o,
  output logic [N_BTN-1:0]         press_o,
  output logic [N_BTN-1:0]         release_o,
  output logic                     busy_o,
  output logic [$clog2(N_BTN)-1:0] owner_o
);

  localparam int MAX_COUNT = DEBOUNCE_PER_NS / PULSE_PER_NS - 1;
  localparam int CW        = (MAX_COUNT > 0) ? $clog2(MAX_COUNT + 1) : 1;
  localparam int OW        = $clog2(N_BTN);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_COUNT);

  typedef enum logic [1:0] {IDLE, COUNT, COMMIT} state_t;

  state_t             state_q, state_d;
  logic [N_BTN-1:0]   sync1_q, sync2_q;
  logic [N_BTN-1:0]   btn_q, btn_d;
  logic [N_BTN-1:0]   press_q, press_d;
  logic [N_BTN-1:0]   release_q, release_d;
  logic [OW-1:0]      owner_q, owner_d;
  logic [OW-1:0]      last_q, last_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [N_BTN-1:0]   req;
  logic               grant_valid;
  logic [OW-1:0]      grant_idx;
  logic [OW:0]        cand;

  assign req = sync2_q ^ btn_q;

  // Scan last+1 .. last+N so the previous owner is considered last.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= N_BTN; k++) begin
      cand = {1'b0, last_q} + (OW+1)'(k);
      if (cand >= (OW+1)'(N_BTN)) cand = cand - (OW+1)'(N_BTN);
      if (!grant_valid && req[cand[OW-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[OW-1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    btn_d     = btn_q;
    press_d   = '0;
    release_d = '0;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          owner_d = grant_idx;
          cnt_d   = '0;
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (sync2_q[owner_q] == btn_q[owner_q]) begin
          last_d  = owner_q;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (tp_i) begin
          if (cnt_q == CNT_LAST) begin
            btn_d[owner_q]     = sync2_q[owner_q];
            press_d[owner_q]   = sync2_q[owner_q];
            release_d[owner_q] = !sync2_q[owner_q];
            state_d            = COMMIT;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      COMMIT: begin
        last_d  = owner_q;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      sync1_q   <= '0;
      sync2_q   <= '0;
      btn_q     <= '0;
      press_q   <= '0;
      release_q <= '0;
      owner_q   <= '0;
      last_q    <= OW'(N_BTN - 1);
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= btn_i;
      sync2_q   <= sync1_q;
      btn_q     <= btn_d;
      press_q   <= press_d;
      release_q <= release_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
    end
  end

  assign btn_o     = btn_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign busy_o    = (state_q != IDLE);
  assign owner_o   = owner_q;

endmodule

// File: tb/tb_debounce_scan.sv
// Bench for debounce_scan: per-cycle comparison against a pulses-remaining model,
// a table of settled patterns, hand sequences for corner cases, and random stimulus.
module tb_debounce_scan;

  localparam int N    = 4;
  localparam int MAXC = 7;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         tp_i;
  logic [N-1:0] btn_i;
  logic [N-1:0] btn_o, press_o, release_o;
  logic         busy_o;
  logic [1:0]   owner_o;

  debounce_scan #(.N_BTN(N), .PULSE_PER_NS(5120), .DEBOUNCE_PER_NS(40960)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .tp_i(tp_i), .btn_i(btn_i),
    .btn_o(btn_o), .press_o(press_o), .release_o(release_o),
    .busy_o(busy_o), .owner_o(owner_o)
  );

  always #5 clk_i = ~clk_i;

  int tests = 0, fails = 0;
  int tp_phase = 0, tp_seen = 0, press_cnt = 0, rel_cnt = 0;

  // Reference model: a window is a number of tp pulses still owed by the owner.
  logic [N-1:0] m_sync1, m_s, m_deb, m_press, m_rel;
  bit           m_active, m_commit;
  int           m_owner, m_last, m_left;

  task automatic model_reset();
    m_sync1 = '0; m_s = '0; m_deb = '0; m_press = '0; m_rel = '0;
    m_active = 0; m_commit = 0; m_owner = 0; m_last = N - 1; m_left = 0;
  endtask

  task automatic model_step(input logic [N-1:0] b, input logic tp);
    m_press = '0;
    m_rel   = '0;
    if (m_commit) begin
      m_commit = 0; m_active = 0; m_last = m_owner;
    end else if (m_active) begin
      if (m_s[m_owner] == m_deb[m_owner]) begin
        m_active = 0; m_last = m_owner;
      end else if (tp) begin
        m_left--;
        if (m_left == 0) begin
          m_deb[m_owner] = m_s[m_owner];
          if (m_s[m_owner]) m_press[m_owner] = 1'b1;
          else              m_rel[m_owner]   = 1'b1;
          m_commit = 1;
        end
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (m_last + k) % N;
        if (!m_active && (m_s[i] != m_deb[i])) begin
          m_active = 1; m_owner = i; m_left = MAXC + 1;
        end
      end
    end
    m_s     = m_sync1;
    m_sync1 = b;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk_i);
    if (rst_i) model_reset();
    else begin
      if (tp_i) tp_seen++;
      model_step(btn_i, tp_i);
    end
    @(negedge clk_i);
    check("cycle_outputs", {17'd0, btn_o, press_o, release_o, busy_o, owner_o},
          {17'd0, m_deb, m_press, m_rel, (m_active | m_commit), 2'(m_owner)});
    press_cnt += $countones(press_o);
    rel_cnt   += $countones(release_o);
    tp_phase = (tp_phase + 1) % 4;
    tp_i = (tp_phase == 0);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    model_reset();
    run(2);
    rst_i = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0] btn;
    logic [N-1:0] exp_btn;
    int           exp_press;
    int           exp_rel;
  } vec_t;

  vec_t tbl[7];
  int   n, p0, p3, t0, t3, s0;
  bit   prev_busy;
  int   order_q[$];

  initial begin
    tbl[0] = '{4'b0001, 4'b0001, 1, 0};
    tbl[1] = '{4'b0111, 4'b0111, 2, 0};
    tbl[2] = '{4'b0010, 4'b0010, 0, 2};
    tbl[3] = '{4'b1111, 4'b1111, 3, 0};
    tbl[4] = '{4'b0000, 4'b0000, 0, 4};
    tbl[5] = '{4'b1010, 4'b1010, 2, 0};
    tbl[6] = '{4'b0101, 4'b0101, 2, 2};

    btn_i = '0; tp_i = 1'b0; rst_i = 1'b1;
    model_reset();
    run(4);
    check("reset_state", {17'd0, btn_o, press_o, release_o, busy_o, owner_o}, 32'd0);
    rst_i = 1'b0;

    for (int i = 0; i < 7; i++) begin
      btn_i = tbl[i].btn; press_cnt = 0; rel_cnt = 0;
      run(200);
      check("tbl_btn_o", 32'(btn_o), 32'(tbl[i].exp_btn));
      check("tbl_press_cnt", press_cnt, tbl[i].exp_press);
      check("tbl_release_cnt", rel_cnt, tbl[i].exp_rel);
      check("tbl_busy_idle", 32'(busy_o), 32'd0);
    end

    // Single press: window of 8 tp pulses after 2-flop sync and grant.
    do_reset();
    btn_i = 4'b0100; press_cnt = 0; rel_cnt = 0; n = 0;
    while (!press_o[2] && n < 100) begin cycle(); n++; end
    check("s1_press_latency_ok", 32'(n >= 32 && n <= 35), 32'd1);
    run(40);
    check("s1_btn_o", 32'(btn_o), 32'h4);
    check("s1_press_once", press_cnt, 1);
    check("s1_no_release", rel_cnt, 0);

    // Bouncy release: short glitches abort; only the final stable low commits.
    rel_cnt = 0;
    repeat (5) begin
      btn_i[2] = 1'b0; run(5);
      btn_i[2] = 1'b1; run(3);
    end
    btn_i[2] = 1'b0; n = 0;
    while (!release_o[2] && n < 100) begin cycle(); n++; end
    check("s4_release_latency_ok", 32'(n >= 32 && n <= 35), 32'd1);
    run(40);
    check("s4_release_once", rel_cnt, 1);
    check("s4_btn_o", 32'(btn_o), 32'h0);

    // Glitch of 3 tp pulses aborts without any event.
    do_reset();
    btn_i = 4'b0010; press_cnt = 0; rel_cnt = 0; n = 0;
    while (!busy_o && n < 20) begin cycle(); n++; end
    check("s2_granted", 32'(busy_o), 32'd1);
    run(12);
    btn_i = 4'b0000;
    run(40);
    check("s2_btn_o", 32'(btn_o), 32'h0);
    check("s2_no_events", press_cnt + rel_cnt, 0);
    check("s2_busy_low", 32'(busy_o), 32'd0);

    // Simultaneous presses on 0 and 3: 0 first, at least one full window apart.
    do_reset();
    btn_i = 4'b1001; p0 = -1; p3 = -1; t0 = 0; t3 = 0;
    for (int c = 0; c < 200; c++) begin
      cycle();
      if (press_o[0] && press_o[3]) check("s3_exclusive", 32'd1, 32'd0);
      if (press_o[0] && p0 < 0) begin p0 = c; t0 = tp_seen; end
      if (press_o[3] && p3 < 0) begin p3 = c; t3 = tp_seen; end
    end
    check("s3_both_pressed", 32'(p0 >= 0 && p3 >= 0), 32'd1);
    check("s3_order", 32'(p3 > p0), 32'd1);
    check("s3_spacing_tp", 32'(t3 - t0 >= 8), 32'd1);

    // Reset at counter = 5 mid-window: immediate clear, then a full new window.
    do_reset();
    btn_i = 4'b0010; n = 0;
    while (!busy_o && n < 20) begin cycle(); n++; end
    s0 = tp_seen; n = 0;
    while (tp_seen - s0 < 5 && n < 40) begin cycle(); n++; end
    rst_i = 1'b1;
    #1;
    model_reset();
    check("s5_async_clear", {17'd0, btn_o, press_o, release_o, busy_o, owner_o}, 32'd0);
    run(2);
    rst_i = 1'b0;
    s0 = tp_seen; n = 0;
    while (!press_o[1] && n < 100) begin cycle(); n++; end
    check("s5_pressed_after", 32'(press_o[1]), 32'd1);
    check("s5_full_window", 32'(tp_seen - s0 >= 8), 32'd1);

    // All buttons held: grants rotate 0,1,2,3.
    do_reset();
    btn_i = 4'b1111; prev_busy = 1'b0; order_q.delete();
    for (int c = 0; c < 250; c++) begin
      cycle();
      if (busy_o && !prev_busy) order_q.push_back(int'(owner_o));
      prev_busy = busy_o;
    end
    check("s6_grant_count", order_q.size(), 4);
    for (int i = 0; i < order_q.size() && i < 4; i++)
      check("s6_grant_order", order_q[i], i);

    // Random stimulus against the model.
    do_reset();
    repeat (40) begin
      btn_i = N'($urandom);
      run($urandom_range(1, 60));
    end
    run(200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
